// File: rtl/lv_owt_rx_ctrl.sv
// lv_owt_rx_ctrl -- one-wire (OWT) frame receiver.
//
// Recovers {wr/rd flag, addr, data} from the serial line driven by the HV-side
// transmitter and presents one decoded request per frame.
// Frame on the line (idle level 0, one symbol = one half-bit of HB_CYC clocks):
//   sync head (>=SYNC_MIN Manchester '0') | NRZ 1100 | Manchester {flag,addr}
//   | Manchester data (ADCD_BW bits for REQ_ADC_ADDR, else DATA_BW) | Manchester CRC8
//   | NRZ 1100
//
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_owt_rx       raw line, synchronized internally by two flops
//   o_rx_vld       1-cycle pulse per decoded frame (good CRC or not)
//   o_rx_wr        flag == WR_OP
//   o_rx_addr      received address
//   o_rx_data      received data, normal frames zero-extended
//   o_rx_crc_err   CRC mismatch, qualified by o_rx_vld
//   o_rx_code_err  1-cycle pulse: Manchester/tail violation or timeout
//   o_rx_busy      receiver is not idle
module lv_owt_rx_ctrl #(
    parameter int                REG_AW       = 7,
    parameter int                DATA_BW      = 8,
    parameter int                ADCD_BW      = 10,
    parameter logic [REG_AW-1:0] REQ_ADC_ADDR = 7'h7F,
    parameter int                SYNC_MIN     = 4,
    parameter int                HB_CYC       = 8,
    parameter logic              WR_OP        = 1'b1,
    parameter logic [7:0]        CRC_POLY     = 8'h07,
    parameter logic [7:0]        CRC_INIT     = 8'h00
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_owt_rx,
    output logic               o_rx_vld,
    output logic               o_rx_wr,
    output logic [REG_AW-1:0]  o_rx_addr,
    output logic [ADCD_BW-1:0] o_rx_data,
    output logic               o_rx_crc_err,
    output logic               o_rx_code_err,
    output logic               o_rx_busy
);

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CMD_BW  = REG_AW + 1;
    localparam int CNT_MAX = imax(imax(imax(CMD_BW, ADCD_BW), imax(DATA_BW, 8)), SYNC_MIN);
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(HB_CYC);
    localparam int QW      = $clog2(4 * HB_CYC);

    localparam logic [PW-1:0] PH_LAST = PW'(HB_CYC - 1);
    localparam logic [PW-1:0] PH_SMP  = PW'(HB_CYC / 2 - 1);
    localparam logic [QW-1:0] Q_LAST  = QW'(4 * HB_CYC - 1);
    localparam logic [CW-1:0] C_SYNC  = CW'(SYNC_MIN);
    localparam logic [CW-1:0] C_CMD_L = CW'(CMD_BW - 1);
    localparam logic [CW-1:0] C_DAT_L = CW'(DATA_BW - 1);
    localparam logic [CW-1:0] C_ADC_L = CW'(ADCD_BW - 1);
    localparam logic [CW-1:0] C_CRC_L = CW'(7);

    typedef enum logic [2:0] {
        ST_IDLE, ST_HEAD, ST_TAIL, ST_CMD, ST_DATA, ST_CRC, ST_END, ST_OUT
    } state_t;

    state_t state, state_nx;

    logic [1:0]         sync_q;
    logic               line, line_d;
    logic               edge_det, rise, smp, timeout;
    logic [PW-1:0]      ph_cnt;
    logic [QW-1:0]      quiet;
    // half: in HEAD, 1 = expecting the '1' half of a sync bit;
    //       in CMD/DATA/CRC, 1 = first half captured, second half pending.
    logic               half;
    logic               first_val;
    logic [CW-1:0]      cnt;
    logic [CMD_BW-1:0]  cmd_sh;
    logic [ADCD_BW-1:0] data_sh;
    logic [7:0]         crc_rx, crc_calc;
    logic               err, bit_ok, fld_last;
    logic [CW-1:0]      fld_len_m1;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        return {c[6:0], 1'b0} ^ (((c[7] ^ b) != 1'b0) ? CRC_POLY : 8'h00);
    endfunction

    assign line     = sync_q[1];
    assign edge_det = line ^ line_d;
    assign rise     = line & ~line_d;
    assign smp      = !edge_det && (ph_cnt == PH_SMP);
    // A legal frame never holds the line for more than three half-bits.
    assign timeout  = (state != ST_IDLE) && (state != ST_OUT) && !edge_det && (quiet == Q_LAST);

    always_comb begin
        fld_len_m1 = C_CRC_L;
        case (state)
            ST_CMD:  fld_len_m1 = C_CMD_L;
            ST_DATA: fld_len_m1 = (cmd_sh[REG_AW-1:0] == REQ_ADC_ADDR) ? C_ADC_L : C_DAT_L;
            default: fld_len_m1 = C_CRC_L;
        endcase
    end
    assign fld_last = (cnt == fld_len_m1);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; err/bit_ok are the per-sample verdicts
    always_comb begin
        state_nx = state;
        err      = 1'b0;
        bit_ok   = 1'b0;
        case (state)
            ST_IDLE: if (rise) state_nx = ST_HEAD;
            ST_HEAD: if (smp) begin
                if (half) begin
                    if (!line) err = 1'b1;
                end else if (line) begin
                    // '1' where a sync first-half '0' was due: tail has begun
                    if (cnt >= C_SYNC) state_nx = ST_TAIL;
                    else               err      = 1'b1;
                end
            end
            ST_TAIL: if (smp) begin
                if (line != (cnt == '0))      err      = 1'b1;
                else if (cnt == CW'(2))       state_nx = ST_CMD;
            end
            ST_CMD, ST_DATA, ST_CRC: if (smp && half) begin
                if (line == first_val) err = 1'b1;
                else begin
                    bit_ok = 1'b1;
                    if (fld_last) begin
                        case (state)
                            ST_CMD:  state_nx = ST_DATA;
                            ST_DATA: state_nx = ST_CRC;
                            default: state_nx = ST_END;
                        endcase
                    end
                end
            end
            ST_END: if (smp) begin
                if (line != (cnt < CW'(2)))   err      = 1'b1;
                else if (cnt == CW'(3))       state_nx = ST_OUT;
            end
            ST_OUT:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
        if (timeout) err = 1'b1;
        if (err) state_nx = ST_IDLE;
    end

    // Output logic
    always_comb begin
        o_rx_vld      = (state == ST_OUT) && !i_rst;
        o_rx_busy     = (state != ST_IDLE);
        o_rx_code_err = err && !i_rst;
    end

    // Line sampling, field shifting, CRC and result registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q       <= '0;
            line_d       <= 1'b0;
            ph_cnt       <= '0;
            quiet        <= '0;
            half         <= 1'b0;
            first_val    <= 1'b0;
            cnt          <= '0;
            cmd_sh       <= '0;
            data_sh      <= '0;
            crc_rx       <= '0;
            crc_calc     <= CRC_INIT;
            o_rx_wr      <= 1'b0;
            o_rx_addr    <= '0;
            o_rx_data    <= '0;
            o_rx_crc_err <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], i_owt_rx};
            line_d <= line;

            if (edge_det || ph_cnt == PH_LAST) ph_cnt <= '0;
            else                               ph_cnt <= ph_cnt + 1'b1;

            if (state == ST_IDLE || edge_det) quiet <= '0;
            else if (quiet != Q_LAST)         quiet <= quiet + 1'b1;

            case (state)
                ST_IDLE: begin
                    // HEAD starts mid first sync bit: its '0' half already
                    // elapsed, so that bit counts and its '1' half is due.
                    half <= 1'b1;
                    cnt  <= CW'(1);
                end
                ST_HEAD: if (smp) begin
                    if (half) half <= 1'b0;
                    else if (!line) begin
                        half <= 1'b1;
                        if (cnt < C_SYNC) cnt <= cnt + 1'b1;
                    end else cnt <= '0;
                end
                ST_TAIL: if (smp) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(2)) begin
                        cnt      <= '0;
                        half     <= 1'b0;
                        cmd_sh   <= '0;
                        data_sh  <= '0;
                        crc_calc <= CRC_INIT;
                    end
                end
                ST_CMD, ST_DATA, ST_CRC: if (smp) begin
                    if (!half) begin
                        first_val <= line;
                        half      <= 1'b1;
                    end else begin
                        half <= 1'b0;
                        cnt  <= fld_last ? '0 : cnt + 1'b1;
                    end
                end
                ST_END: if (smp) cnt <= cnt + 1'b1;
                default: ;
            endcase

            if (bit_ok) begin
                case (state)
                    ST_CMD: begin
                        cmd_sh   <= {cmd_sh[CMD_BW-2:0], first_val};
                        crc_calc <= crc_step(crc_calc, first_val);
                    end
                    ST_DATA: begin
                        data_sh  <= {data_sh[ADCD_BW-2:0], first_val};
                        crc_calc <= crc_step(crc_calc, first_val);
                    end
                    default: crc_rx <= {crc_rx[6:0], first_val};
                endcase
            end

            // Results become visible together with the o_rx_vld pulse
            if (state_nx == ST_OUT) begin
                o_rx_wr      <= (cmd_sh[CMD_BW-1] == WR_OP);
                o_rx_addr    <= cmd_sh[REG_AW-1:0];
                o_rx_data    <= data_sh;
                o_rx_crc_err <= (crc_calc != crc_rx);
            end
        end
    end

endmodule

// File: tb/tb_lv_owt_rx_ctrl.sv
// Bench for lv_owt_rx_ctrl: directed frames plus randomized frames, each
// built as a list of half-bit line symbols from the frame rules, with the
// CRC derived by polynomial long division.
module tb_lv_owt_rx_ctrl;
    localparam int HB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       owt = 1'b0;
    logic       vld, wr, crc_err, code_err, busy;
    logic [6:0] addr;
    logic [9:0] data;

    lv_owt_rx_ctrl #(.HB_CYC(HB)) dut (
        .i_clk(clk), .i_rst(rst), .i_owt_rx(owt),
        .o_rx_vld(vld), .o_rx_wr(wr), .o_rx_addr(addr), .o_rx_data(data),
        .o_rx_crc_err(crc_err), .o_rx_code_err(code_err), .o_rx_busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    bit         syms[$];
    logic       e_wr, e_crc;
    logic [6:0] e_addr;
    logic [9:0] e_data;
    int         v0, c0;

    // Output monitor (single writer of the captured values)
    int         vld_tot = 0, cerr_tot = 0;
    logic       cap_wr = 1'b0, cap_crc = 1'b0;
    logic [6:0] cap_addr = '0;
    logic [9:0] cap_data = '0;
    logic       prev_cerr = 1'b0, busy_after = 1'b1;

    always @(negedge clk) begin
        prev_cerr <= code_err;
        if (prev_cerr) busy_after <= busy;
        if (vld) begin
            vld_tot  <= vld_tot + 1;
            cap_wr   <= wr;
            cap_addr <= addr;
            cap_data <= data;
            cap_crc  <= crc_err;
        end
        if (code_err) cerr_tot <= cerr_tot + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_man(input bit b);
        syms.push_back(b);
        syms.push_back(~b);
    endtask

    function automatic logic [7:0] crc_ref(input bit msg[$]);
        bit         m[$];
        logic [8:0] g = 9'h107;
        logic [7:0] r;
        m = msg;
        repeat (8) m.push_back(1'b0);
        for (int i = 0; i < msg.size(); i++)
            if (m[i]) for (int k = 0; k < 9; k++) m[i+k] = m[i+k] ^ g[8-k];
        for (int j = 0; j < 8; j++) r[7-j] = m[msg.size()+j];
        return r;
    endfunction

    task automatic build(input bit w, input logic [6:0] a, input logic [9:0] d,
                         input int nsync, input logic [7:0] flip);
        bit         msg[$];
        int         dlen;
        logic [7:0] c;
        syms.delete();
        dlen = (a == 7'h7F) ? 10 : 8;
        msg.push_back(w);
        for (int i = 6; i >= 0; i--) msg.push_back(a[i]);
        for (int i = dlen - 1; i >= 0; i--) msg.push_back(d[i]);
        c = crc_ref(msg) ^ flip;
        repeat (nsync) push_man(1'b0);
        syms.push_back(1'b1); syms.push_back(1'b1); syms.push_back(1'b0); syms.push_back(1'b0);
        foreach (msg[i]) push_man(msg[i]);
        for (int i = 7; i >= 0; i--) push_man(c[i]);
        syms.push_back(1'b1); syms.push_back(1'b1); syms.push_back(1'b0); syms.push_back(1'b0);
        repeat (4) syms.push_back(1'b0);
        e_wr   = w;
        e_addr = a;
        e_data = (dlen == 10) ? d : {2'b00, d[7:0]};
        e_crc  = (flip != 8'h00);
    endtask

    task automatic truncate(input int keep);
        while (syms.size() > keep) void'(syms.pop_back());
    endtask

    task automatic send(input bit jit, input int post);
        int len;
        v0 = vld_tot;
        c0 = cerr_tot;
        foreach (syms[i]) begin
            owt = syms[i];
            len = jit ? HB - 1 + int'($urandom_range(2)) : HB;
            repeat (len) @(posedge clk);
            #1;
        end
        repeat (post) @(posedge clk);
        #1;
    endtask

    task automatic check_ok(input string t);
        chk({t, ".vld"},  vld_tot - v0, 1);
        chk({t, ".cerr"}, cerr_tot - c0, 0);
        chk({t, ".wr"},   cap_wr, e_wr);
        chk({t, ".addr"}, cap_addr, e_addr);
        chk({t, ".data"}, cap_data, e_data);
        chk({t, ".crc"},  cap_crc, e_crc);
    endtask

    task automatic check_err(input string t);
        chk({t, ".cerr"}, cerr_tot - c0, 1);
        chk({t, ".vld"},  vld_tot - v0, 0);
    endtask

    initial begin
        int idx;
        logic [6:0] ra;
        logic [7:0] rf;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.vld", vld, 0);      chk("rst.busy", busy, 0);
        chk("rst.cerr", code_err, 0); chk("rst.wr", wr, 0);
        chk("rst.addr", addr, 0);    chk("rst.data", data, 0);
        chk("rst.crc", crc_err, 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // 1: write 0x12 / 0xA5
        build(1'b1, 7'h12, 10'h0A5, 5, 8'h00);
        send(1'b0, 3 * HB);
        check_ok("t1");
        chk("t1.idle", busy, 0);

        // 2: ADC read, 10 data bits
        build(1'b0, 7'h7F, 10'h2C3, 4, 8'h00);
        send(1'b0, 3 * HB);
        check_ok("t2");

        // 3: CRC LSB flipped
        build(1'b1, 7'h12, 10'h0A5, 4, 8'h01);
        send(1'b0, 3 * HB);
        check_ok("t3");

        // 4: cmd bit 3 second half not inverted
        build(1'b1, 7'h12, 10'h0A5, 5, 8'h00);
        idx = 5 * 2 + 4 + 3 * 2 + 1;
        syms[idx] = syms[idx-1];
        truncate(idx + 1);
        repeat (4) syms.push_back(1'b0);
        send(1'b0, 3 * HB);
        check_err("t4");
        chk("t4.busy_next", busy_after, 0);
        chk("t4.hold_addr", addr, 7'h12);
        chk("t4.hold_data", data, 10'h0A5);
        chk("t4.hold_wr", wr, 1);

        // 5a: only three sync bits
        build(1'b1, 7'h12, 10'h0A5, 3, 8'h00);
        truncate(3 * 2 + 4);
        repeat (4) syms.push_back(1'b0);
        send(1'b0, 3 * HB);
        check_err("t5a");

        // 5b: line stuck high 40 cycles in the data field
        build(1'b0, 7'h33, 10'h05A, 4, 8'h00);
        truncate(4 * 2 + 4 + (8 + 3) * 2);
        repeat (5) syms.push_back(1'b1);
        repeat (4) syms.push_back(1'b0);
        send(1'b0, 3 * HB);
        check_err("t5b");

        // 6: reset mid-data, then a full frame with jitter
        build(1'b0, 7'h21, 10'h03C, 4, 8'h00);
        truncate(4 * 2 + 4 + (8 + 4) * 2);
        send(1'b0, 0);
        owt = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t6.rst_busy", busy, 0);
        chk("t6.rst_addr", addr, 0);
        chk("t6.rst_data", data, 0);
        chk("t6.rst_wr", wr, 0);
        rst = 1'b0;
        repeat (2 * HB) @(posedge clk);
        #1;
        chk("t6.no_vld", vld_tot - v0, 0);
        chk("t6.no_cerr", cerr_tot - c0, 0);
        build(1'b1, 7'h12, 10'h0A5, 4, 8'h00);
        send(1'b1, 3 * HB);
        check_ok("t6");

        // Randomized frames with jitter
        for (int n = 0; n < 8; n++) begin
            ra = ($urandom_range(3) == 0) ? 7'h7F : 7'($urandom);
            rf = ($urandom_range(3) == 0) ? (8'h01 << $urandom_range(7)) : 8'h00;
            build(1'($urandom), ra, 10'($urandom), 4 + int'($urandom_range(3)), rf);
            send(1'b1, 3 * HB);
            check_ok("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
